// File: rtl/multi_port_lutram_if.sv
// multi_port_lutram_if: write/read bus bundle for the multi-port LUTRAM
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

interface multi_port_lutram_if #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int NUM_READ_PORT             = 2
);
    logic                                           ready_out;
    logic [WRITE_MASK_LEN-1:0]                      write_en_in;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]               write_set_addr_in;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]           write_entry_in;
    logic [NUM_READ_PORT-1:0]                       read_en_in;
    logic [NUM_READ_PORT*SET_PTR_WIDTH_IN_BITS-1:0] read_set_addr_in;
    logic [NUM_READ_PORT*SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out;
    logic [NUM_READ_PORT-1:0]                       read_valid_out;

    modport master (
        input  ready_out, read_entry_out, read_valid_out,
        output write_en_in, write_set_addr_in, write_entry_in, read_en_in, read_set_addr_in
    );

    modport slave (
        output ready_out, read_entry_out, read_valid_out,
        input  write_en_in, write_set_addr_in, write_entry_in, read_en_in, read_set_addr_in
    );
endinterface

// File: rtl/multi_port_lutram.sv
// multi_port_lutram: byte-masked single-write, multi-read distributed RAM with init sweep and bypass
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module multi_port_lutram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int NUM_READ_PORT             = 2,
    parameter int READ_LATENCY              = 1,
    parameter int BYPASS_EN                 = 1
) (
    input logic                clk_in,
    input logic                reset_n_in,
    multi_port_lutram_if.slave bus
);
    localparam int E = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int W = SET_PTR_WIDTH_IN_BITS;
    localparam int B = `BYTE_LEN_IN_BITS;

    typedef enum logic {INIT, READY} state_t;

    state_t                     state_q;
    logic [W-1:0]               init_ptr_q;
    logic                       ready_q;
    (* ram_style = "distributed" *) logic [E-1:0] lutram [NUM_SET];
    logic                       wr_active;
    logic [NUM_READ_PORT-1:0]   rd_accept;
    logic [NUM_READ_PORT*E-1:0] s1_data_d;
    logic [NUM_READ_PORT*E-1:0] s1_data_q;
    logic [NUM_READ_PORT-1:0]   s1_valid_q;

    // Ports are live only once the sweep has finished; reset also masks them.
    always_comb begin
        wr_active = reset_n_in && (state_q == READY) && (|bus.write_en_in);
        rd_accept = (reset_n_in && state_q == READY) ? bus.read_en_in : '0;
    end

    // Old array content per port, with the written lanes forwarded on an address hit when bypass is on.
    always_comb begin
        s1_data_d = '0;
        for (int p = 0; p < NUM_READ_PORT; p++) begin
            s1_data_d[p*E +: E] = lutram[bus.read_set_addr_in[p*W +: W]];
            if (BYPASS_EN != 0 && wr_active && bus.read_set_addr_in[p*W +: W] == bus.write_set_addr_in) begin
                for (int i = 0; i < WRITE_MASK_LEN; i++) begin
                    if (bus.write_en_in[i]) s1_data_d[p*E + i*B +: B] = bus.write_entry_in[i*B +: B];
                end
            end
        end
    end

    // Init sweep FSM: one entry zeroed per edge, READY after the last entry.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else if (state_q == INIT) begin
            init_ptr_q <= init_ptr_q + W'(1);
            if (init_ptr_q == W'(NUM_SET - 1)) begin
                state_q <= READY;
                ready_q <= 1'b1;
            end
        end
    end

    // Array storage carries no reset so it maps onto LUT RAM; the sweep zeroes it instead.
    always_ff @(posedge clk_in) begin
        if (reset_n_in && state_q == INIT) begin
            lutram[init_ptr_q] <= '0;
        end else if (wr_active) begin
            for (int i = 0; i < WRITE_MASK_LEN; i++) begin
                if (bus.write_en_in[i]) lutram[bus.write_set_addr_in][i*B +: B] <= bus.write_entry_in[i*B +: B];
            end
        end
    end

    // First read stage: data only reloads on an accepted request so it holds otherwise.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            s1_valid_q <= '0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_accept;
            for (int p = 0; p < NUM_READ_PORT; p++) begin
                if (rd_accept[p]) s1_data_q[p*E +: E] <= s1_data_d[p*E +: E];
            end
        end
    end

    assign bus.ready_out = ready_q;

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign bus.read_entry_out = s1_data_q;
            assign bus.read_valid_out = s1_valid_q;
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic [NUM_READ_PORT*E-1:0] s2_data_q;
            logic [NUM_READ_PORT-1:0]   s2_valid_q;
            // Second read stage: a snapshot of stage one, immune to later writes.
            always_ff @(posedge clk_in) begin
                if (!reset_n_in) begin
                    s2_valid_q <= '0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    for (int p = 0; p < NUM_READ_PORT; p++) begin
                        if (s1_valid_q[p]) s2_data_q[p*E +: E] <= s1_data_q[p*E +: E];
                    end
                end
            end
            assign bus.read_entry_out = s2_data_q;
            assign bus.read_valid_out = s2_valid_q;
        end else begin : g_bad_latency
            $error("multi_port_lutram: READ_LATENCY must be 1 or 2");
        end
    endgenerate
endmodule
